// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command stream into APB3 transfers, one in flight.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
//
// state    | meaning
// S_IDLE   | req_ready high; psel/penable low; address/data hold last values
// S_SETUP  | psel high, penable low, exactly one cycle
// S_ACCESS | psel and penable high until pready (or timeout)
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_timeout;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Down-counter loaded while in SETUP; terminal count marks the last allowed ACCESS cycle.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_SETUP) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == S_ACCESS && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == S_ACCESS) && !pready && (r_cnt == '0);
`else
    // No timeout: ACCESS waits for pready indefinitely; the parameter is only referenced here.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        w_accept  = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SETUP;
                end
            end
            S_SETUP: begin
                psel   = 1'b1;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done | w_timeout;
            if (w_accept) begin
                r_pwrite <= req_write;
                r_paddr  <= req_addr;
                r_pwdata <= req_wdata;
            end
            // Response fields hold between pulses so the requester can read them late.
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? '0 : prdata;
                r_rsp_err   <= pslverr;
            end else if (w_timeout) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level model plus a memory-backed APB slave.
// Timeout checks are included when APB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_apb_master_bridge;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk     (pclk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    logic [DW-1:0] slv_mem [1024];
    logic [DW-1:0] mdl_mem [1024];
    int next_waits = 0;
    int wait_left = 0;

    // Transaction model: one command in flight, response fields hold between pulses.
    bit            m_active, m_setup, m_accepted, m_pwrite;
    bit            m_rsp_valid, m_rsp_err;
    int            m_acc;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata, m_rsp_rdata;

    int pen_cnt = 0;
    int rsp_cnt = 0;
    int setup_log[$];
    logic [DW-1:0] rsp_log[$];

    function automatic bit is_err(logic [AW-1:0] a);
        return a[11:8] == 4'hF;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cycle);
        end
    endtask

    task automatic model_reset();
        m_active    = 0;
        m_setup     = 0;
        m_accepted  = 0;
        m_pwrite    = 0;
        m_rsp_valid = 0;
        m_rsp_err   = 0;
        m_acc       = 0;
        m_paddr     = '0;
        m_pwdata    = '0;
        m_rsp_rdata = '0;
    endtask

    task automatic model_step();
        m_accepted = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_rsp_valid = 0;
        if (!m_active) begin
            if (req_valid) begin
                m_active   = 1;
                m_setup    = 1;
                m_accepted = 1;
                m_pwrite   = req_write;
                m_paddr    = req_addr;
                m_pwdata   = req_wdata;
            end
        end else if (m_setup) begin
            m_setup = 0;
            m_acc   = 0;
        end else begin
            m_acc++;
            if (pready) begin
                m_active    = 0;
                m_rsp_valid = 1;
                m_rsp_err   = is_err(m_paddr);
                m_rsp_rdata = m_pwrite ? '0 : mdl_mem[m_paddr[11:2]];
                if (m_pwrite && !is_err(m_paddr)) mdl_mem[m_paddr[11:2]] = m_pwdata;
            end
`ifdef APB_TIMEOUT_EN
            else if (m_acc == TO) begin
                m_active    = 0;
                m_rsp_valid = 1;
                m_rsp_err   = 1;
                m_rsp_rdata = '0;
            end
`endif
        end
    endtask

    task automatic compare();
        chk("psel", psel, m_active);
        chk("penable", penable, m_active && !m_setup);
        if (rst_n) chk("req_ready", req_ready, !m_active);
        chk("paddr", paddr, m_paddr);
        chk("pwrite", pwrite, m_pwrite);
        chk("pwdata", pwdata, m_pwdata);
        chk("rsp_valid", rsp_valid, m_rsp_valid);
        chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
        chk("rsp_err", rsp_err, m_rsp_err);
    endtask

    // Memory-backed slave; garbage on pready/prdata/pslverr outside the handshake.
    task automatic slave_drive();
        pready  = 1'($urandom_range(0, 1));
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
        if (psel && !penable) begin
            wait_left = next_waits;
        end else if (psel && penable) begin
            if (wait_left > 0) begin
                pready = 1'b0;
                wait_left--;
            end else begin
                pready  = 1'b1;
                pslverr = is_err(paddr);
                prdata  = slv_mem[paddr[11:2]];
                if (pwrite && !is_err(paddr)) slv_mem[paddr[11:2]] = pwdata;
            end
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        cycle++;
        model_step();
        #1;
        compare();
        if (psel && !penable) setup_log.push_back(cycle);
        if (penable) pen_cnt++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_log.push_back(rsp_rdata);
        end
        @(negedge pclk);
        slave_drive();
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!m_rsp_valid && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!m_rsp_valid) begin
            failures++;
            $display("FAIL rsp_wait actual=no_response required=response cycle=%0d", cycle);
        end
    endtask

    task automatic run_cmd(bit w, logic [AW-1:0] a, logic [DW-1:0] d, int waits);
        int n = 0;
        next_waits = waits;
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        do begin
            tick();
            n++;
        end while (!m_accepted && n < 50);
        checks++;
        if (!m_accepted) begin
            failures++;
            $display("FAIL accept_wait actual=not_accepted required=accepted cycle=%0d", cycle);
        end
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        wait_rsp();
    endtask

    task automatic load_b2b(int k);
        case (k)
            0: begin req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hA5A5_0001; end
            1: begin req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; end
            default: begin req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678; end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished cycle=%0d", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int n;
        for (int i = 0; i < 1024; i++) begin
            slv_mem[i] = $urandom;
            mdl_mem[i] = slv_mem[i];
        end
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_psel", psel, 0);
        chk("reset_paddr", paddr, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);

        // Zero-wait write.
        pen_cnt = 0;
        setup_log.delete();
        run_cmd(1'b1, 32'h04, 32'hDEAD_BEEF, 0);
        chk("wr_setup_cycles", setup_log.size(), 1);
        chk("wr_penable_cycles", pen_cnt, 1);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_psel_low", psel, 0);
        chk("wr_slave_mem", slv_mem[1], 32'hDEAD_BEEF);

        // Read with three wait states.
        pen_cnt = 0;
        run_cmd(1'b0, 32'h04, 32'h0, 3);
        chk("rd_penable_cycles", pen_cnt, 4);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", rsp_err, 0);
        chk("rd_paddr", paddr, 32'h04);

        // Slave error.
        run_cmd(1'b0, 32'hFFC, 32'h0, 0);
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_err", rsp_err, 1);

        // Back-to-back with req_valid held.
        setup_log.delete();
        rsp_log.delete();
        rsp_cnt    = 0;
        next_waits = 0;
        k          = 0;
        n          = 0;
        req_valid  = 1'b1;
        load_b2b(0);
        while ((k < 3 || m_active) && n < 40) begin
            tick();
            n++;
            if (m_accepted) begin
                k++;
                if (k < 3) load_b2b(k);
                else req_valid = 1'b0;
            end
        end
        chk("b2b_setups", setup_log.size(), 3);
        if (setup_log.size() == 3) begin
            chk("b2b_spacing1", setup_log[1] - setup_log[0], 3);
            chk("b2b_spacing2", setup_log[2] - setup_log[1], 3);
        end
        chk("b2b_rsp_count", rsp_cnt, 3);
        if (rsp_log.size() == 3) begin
            chk("b2b_rsp0", rsp_log[0], 0);
            chk("b2b_rsp1", rsp_log[1], 32'hA5A5_0001);
            chk("b2b_rsp2", rsp_log[2], 0);
        end

        // Reset in the middle of ACCESS.
        next_waits = 10;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rst_pre_penable", penable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_psel", psel, 0);
        chk("rst_async_penable", penable, 0);
        chk("rst_async_paddr", paddr, 0);
        model_reset();
        tick();
        rst_n   = 1'b1;
        rsp_cnt = 0;
        repeat (3) tick();
        chk("rst_no_rsp", rsp_cnt, 0);
        run_cmd(1'b1, 32'h30, 32'hC0FF_EE00, 1);
        chk("rst_after_wr_err", rsp_err, 0);
        run_cmd(1'b0, 32'h30, 32'h0, 2);
        chk("rst_after_rd", rsp_rdata, 32'hC0FF_EE00);

`ifdef APB_TIMEOUT_EN
        pen_cnt = 0;
        run_cmd(1'b0, 32'h40, 32'h0, 1000);
        chk("to_penable_cycles", pen_cnt, TO);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_req_ready", req_ready, 1);
        pen_cnt = 0;
        run_cmd(1'b0, 32'h04, 32'h0, TO - 1);
        chk("to_edge_penable", pen_cnt, TO);
        chk("to_edge_rsp_err", rsp_err, 0);
        chk("to_edge_rdata", rsp_rdata, 32'hDEAD_BEEF);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_cmd(1'($urandom_range(0, 1)), {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                    $urandom, $urandom_range(0, 3));
        end
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester that converts a simple valid/ready command interface into APB3 transfers. It drives the existing APB slave through the shared APB interface signals.
- Sits between the bench or CPU-side command source and the APB slave, and returns one response per accepted command.
- Single outstanding transfer at a time; no pipelining across APB transfers.

Parameters:
- ADDR_WIDTH, 32, width of req_addr/paddr
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with the optional feature); must be >= 1

Ports:
- pclk  input  1  APB clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  command present
- req_ready  output  1  bridge can accept a command
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  command address
- req_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
- rsp_err  output  1  slave error (or timeout)
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB slave error

Behaviour:
- Reset: asynchronous on rst_n low. The FSM goes to IDLE and outputs are: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1 once rst_n is high.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
  - SETUP: psel=1, penable=0, for exactly 1 cycle, then go to ACCESS.
  - ACCESS: psel=1, penable=1. Stay while pready=0. On pready=1, sample prdata (reads only) and pslverr, then go to IDLE.
- Response: rsp_valid=1 in the cycle after the pready handshake, for 1 cycle only. rsp_rdata and rsp_err are valid with it and hold until the next response. For writes, rsp_rdata=0.
- Signal timing:
  - req_ready is 0 in SETUP and ACCESS.
  - req_ready is 1 in the same cycle as rsp_valid, so a new command can be accepted then.
  - Minimum command-to-command spacing is 3 cycles (accept, SETUP, ACCESS with pready=1).
  - psel and penable deassert in the cycle after the pready handshake.
- Hold rules: paddr, pwrite and pwdata are stable from SETUP through the last ACCESS cycle. They keep their last values in IDLE.
- pslverr and prdata are ignored unless psel&penable&pready.
- req_* inputs are ignored outside IDLE. A held req_valid is accepted only when re-entering IDLE.
- Reset mid-transfer: the transfer is abandoned, no rsp_valid is issued, and all outputs take their reset values immediately.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro defined:
  - An ACCESS-cycle counter clears on entry to ACCESS.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the FSM goes to IDLE and drops psel/penable.
  - rsp_valid=1 with rsp_err=1 and rsp_rdata=0.
  - pready=1 in the final counted cycle wins over the timeout.
- Without the macro: there is no counter, and ACCESS waits indefinitely for pready.

Test Plan:
- Write, zero wait states: req addr=0x04, wdata=0xDEADBEEF, pready=1. Required response:
  - SETUP 1 cycle, then ACCESS 1 cycle.
  - Next cycle rsp_valid=1, rsp_err=0, rsp_rdata=0.
  - Slave location 0x04 holds 0xDEADBEEF.
- Read with 3 wait states: read addr=0x04, pready low for 3 ACCESS cycles, prdata=0xDEADBEEF. Required response:
  - penable high for 4 cycles.
  - rsp_rdata=0xDEADBEEF, rsp_err=0.
  - paddr stable throughout.
- Slave error: read addr=0xFFC with pready=1, pslverr=1 -> rsp_valid=1, rsp_err=1.
- Back-to-back: req_valid held high with 3 commands queued -> accepts occur 3 cycles apart; exactly 3 rsp_valid pulses, in order.
- Reset mid-ACCESS: assert rst_n=0 while penable=1 and pready=0 -> psel/penable go to 0 without waiting for pclk; no rsp_valid; after release, a new write completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16: pready tied 0 -> after 16 ACCESS cycles rsp_valid=1, rsp_err=1, rsp_rdata=0, FSM back in IDLE.
